// File: rtl/dmem_pkg.sv
// Shared constants, FSM encoding and address helper for the data memory responder.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    typedef struct packed {
        logic              we;
        logic              err;
        logic [BE_W-1:0]   be;
        logic [WORD_W-1:0] wdata;
    } cap_t;

    // Byte address to full word index; callers keep the low bits they need.
    function automatic logic [WORD_W-1:0] word_idx(input logic [WORD_W-1:0] a);
        return {2'b00, a[WORD_W-1:2]};
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-wide storage with synchronous per-byte write and asynchronous read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     idx,
    input  logic [WORD_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [WORD_W-1:0] rdata
);

    logic [BE_W-1:0][7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) mem[idx][i] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_resp.sv
// Data memory with fixed wait states and a one-cycle ack.
// Define DMEM_RANGE_ERR_EN to fault accesses beyond the array instead of wrapping.
module data_mem_resp
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic              ready,
    output logic              ack,
    output logic [WORD_W-1:0] rdata,
    output logic              err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LD =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [1:0] S_NEXT =
        (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;

    logic [1:0]        state;
    logic [3:0]        cnt;
    cap_t              cap;
    logic [AW-1:0]     cap_idx;
    logic [WORD_W-1:0] widx;
    logic              oor;
    logic              rng_err;
    logic              wr_en;
    logic [WORD_W-1:0] mem_rdata;
    logic              unused_ok;

    assign widx = word_idx(addr);
    assign oor  = (widx >> AW) != '0;

`ifdef DMEM_RANGE_ERR_EN
    assign rng_err   = oor;
    assign unused_ok = ^addr[1:0];
`else
    assign rng_err   = 1'b0;
    assign unused_ok = ^{addr[1:0], oor};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            cap     <= '0;
            cap_idx <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req) begin
                        state     <= S_NEXT;
                        cnt       <= CNT_LD;
                        cap.we    <= we;
                        cap.err   <= rng_err;
                        cap.be    <= be;
                        cap.wdata <= wdata;
                        cap_idx   <= widx[AW-1:0];
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) state <= S_RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ready = (state == S_IDLE) & ~rst;
    assign ack   = (state == S_RESP) & ~rst;
    // Faulted stores never reach the array.
    assign wr_en = ack & cap.we & ~cap.err;
    assign rdata = (ack & ~cap.we & ~cap.err) ? mem_rdata : '0;

`ifdef DMEM_RANGE_ERR_EN
    assign err = ack & cap.err;
`else
    assign err = 1'b0;
`endif

    dmem_array #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (wr_en),
        .idx   (cap_idx),
        .wdata (cap.wdata),
        .be    (cap.be),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench: directed table, reset/throughput sequences, random vs byte model.
module tb_data_mem_resp;

`ifdef DMEM_RANGE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req2 = 0, we2 = 0;
    logic [31:0] addr2 = 0, wdata2 = 0;
    logic [3:0]  be2 = 0;
    logic        ready2, ack2, err2;
    logic [31:0] rdata2;

    logic        req0 = 0, we0 = 0;
    logic [31:0] addr0 = 0, wdata0 = 0;
    logic [3:0]  be0 = 0;
    logic        ready0, ack0, err0;
    logic [31:0] rdata0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_mem_resp #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .we(we2), .addr(addr2),
        .wdata(wdata2), .be(be2), .ready(ready2), .ack(ack2),
        .rdata(rdata2), .err(err2)
    );

    data_mem_resp #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0),
        .wdata(wdata0), .be(be0), .ready(ready0), .ack(ack0),
        .rdata(rdata0), .err(err0)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        chk(name, {31'd0, got}, {31'd0, exp});
    endtask

    // Ack-timing monitors: pre-edge view, ack must come exactly W edges after the capture edge.
    int age2 = -1;
    int age0 = -1;
    always @(posedge clk) begin
        if (rst) age2 = -1;
        else begin
            if (ack2) begin
                chk("mon2_ack_age", age2, 2);
                age2 = -1;
            end else if (age2 >= 0) begin
                age2++;
                if (age2 > 2) begin
                    chk("mon2_ack_missing", age2, 2);
                    age2 = -1;
                end
            end
            if (ready2 && req2) age2 = 0;
        end
    end
    always @(posedge clk) begin
        if (rst) age0 = -1;
        else begin
            if (ack0) begin
                chk("mon0_ack_age", age0, 0);
                age0 = -1;
            end else if (age0 >= 0) begin
                chk("mon0_ack_missing", age0, 0);
                age0 = -1;
            end
            if (ready0 && req0) age0 = 0;
        end
    end

    // Reference model: flat byte memory, addresses interpreted directly.
    bit [7:0] mb [1024];

    function automatic void model(input bit w, input logic [31:0] a, input logic [31:0] d,
                                  input logic [3:0] b, output logic [31:0] rd, output logic e);
        int base;
        rd = '0;
        e  = 1'b0;
        if (ERR_EN && a >= 32'd1024) begin
            e = 1'b1;
            return;
        end
        base = int'((a / 4) % 256) * 4;
        if (w) begin
            for (int i = 0; i < 4; i++) if (b[i]) mb[base + i] = d[8*i +: 8];
        end else begin
            rd = {mb[base + 3], mb[base + 2], mb[base + 1], mb[base]};
        end
    endfunction

    task automatic txn2(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output logic [31:0] rd, output logic e);
        int n;
        @(negedge clk);
        chk1("t2_ready_idle", ready2, 1'b1);
        req2 = 1; we2 = w; addr2 = a; wdata2 = d; be2 = b;
        @(posedge clk); #1;
        req2 = 0;
        n = 1;
        while (!ack2 && n < 40) begin
            if (ready2) chk1("t2_ready_busy", ready2, 1'b0);
            @(posedge clk); #1;
            n++;
        end
        chk1("t2_ack_seen", ack2, 1'b1);
        chk("t2_ack_latency", n, 3);
        rd = rdata2;
        e  = err2;
        @(posedge clk); #1;
        chk1("t2_ack_pulse", ack2, 1'b0);
        chk1("t2_ready_back", ready2, 1'b1);
    endtask

    task automatic txn0(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] b, output logic [31:0] rd);
        @(negedge clk);
        chk1("t0_ready_idle", ready0, 1'b1);
        req0 = 1; we0 = w; addr0 = a; wdata0 = d; be0 = b;
        @(posedge clk); #1;
        req0 = 0;
        chk1("t0_ack", ack0, 1'b1);
        chk1("t0_err", err0, 1'b0);
        rd = rdata0;
        @(posedge clk); #1;
        chk1("t0_ack_pulse", ack0, 1'b0);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t        tbl [14];
    logic [31:0] rd;
    logic        e;
    logic [31:0] erd;
    logic        ee;
    int          acks;
    int          k;

    initial begin
        tbl[0]  = '{1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0, 0};
        tbl[1]  = '{0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 0};
        tbl[2]  = '{1, 32'h20,  32'h11223344, 4'hF, 32'h0, 0};
        tbl[3]  = '{1, 32'h20,  32'h000000AA, 4'h1, 32'h0, 0};
        tbl[4]  = '{0, 32'h20,  32'h0,        4'hF, 32'h112233AA, 0};
        tbl[5]  = '{1, 32'h20,  32'h55660000, 4'hC, 32'h0, 0};
        tbl[6]  = '{0, 32'h20,  32'hFFFFFFFF, 4'h0, 32'h556633AA, 0};
        tbl[7]  = '{1, 32'h20,  32'hFFFFFFFF, 4'h0, 32'h0, 0};
        tbl[8]  = '{0, 32'h23,  32'h0,        4'h0, 32'h556633AA, 0};
        tbl[9]  = '{1, 32'h0,   32'h0BADF00D, 4'hF, 32'h0, 0};
        tbl[10] = '{0, 32'h400, 32'h0,        4'hF,
                    ERR_EN ? 32'h0 : 32'h0BADF00D, ERR_EN};
        tbl[11] = '{1, 32'h4,   32'h11111111, 4'hF, 32'h0, 0};
        tbl[12] = '{1, 32'h404, 32'h22222222, 4'hF, 32'h0, ERR_EN};
        tbl[13] = '{0, 32'h4,   32'h0,        4'h0,
                    ERR_EN ? 32'h11111111 : 32'h22222222, 0};

        #2;
        chk1("rst_ready", ready2, 1'b0);
        chk1("rst_ack", ack2, 1'b0);
        chk("rst_rdata", rdata2, 32'h0);
        chk1("rst_err", err2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        chk1("post_rst_ready", ready2, 1'b1);

        for (int i = 0; i < 14; i++) begin
            txn2(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, rd, e);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
            chk1($sformatf("tbl%0d_err", i), e, tbl[i].exp_err);
        end

        // Reset in WAIT drops the pending store.
        txn2(1, 32'h40, 32'hA5A5A5A5, 4'hF, rd, e);
        @(negedge clk);
        req2 = 1; we2 = 1; addr2 = 32'h40; wdata2 = 32'h12345678; be2 = 4'hF;
        @(posedge clk); #1;
        req2 = 0;
        chk1("wait_ready", ready2, 1'b0);
        #1 rst = 1;
        #1;
        chk1("mid_rst_ready", ready2, 1'b0);
        chk1("mid_rst_ack", ack2, 1'b0);
        @(negedge clk);
        chk1("mid_rst_ready2", ready2, 1'b0);
        @(negedge clk);
        rst = 0;
        #1;
        chk1("rel_ready", ready2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk1("rel_no_ack", ack2, 1'b0);
        end
        txn2(0, 32'h40, 32'h0, 4'h0, rd, e);
        chk("rst_kept_word", rd, 32'hA5A5A5A5);
        txn2(0, 32'h10, 32'h0, 4'h0, rd, e);
        chk("rst_mem_kept", rd, 32'hDEADBEEF);

        // Zero wait states, request held for six edges.
        txn0(1, 32'h8C, 32'hFFFFFFFF, 4'hF, rd);
        @(negedge clk);
        acks = 0;
        k = 0;
        req0 = 1; we0 = 1; addr0 = 32'h80; wdata0 = 32'd1; be0 = 4'hF;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk1("hold_ready", ready0, (c % 2) == 1);
            chk1("hold_ack", ack0, (c % 2) == 0);
            if (ack0) begin
                acks++;
                k++;
                addr0 = 32'h80 + 32'(4 * k);
                wdata0 = 32'(k + 1);
            end
        end
        @(negedge clk);
        req0 = 0;
        chk("hold_acks", acks, 3);
        for (int i = 0; i < 3; i++) begin
            txn0(0, 32'h80 + 32'(4 * i), 32'h0, 4'h0, rd);
            chk("hold_word", rd, 32'(i + 1));
        end
        txn0(0, 32'h8C, 32'h0, 4'h0, rd);
        chk("hold_no_extra", rd, 32'hFFFFFFFF);

        // Random mix against the byte model.
        for (int i = 0; i < 256; i++) begin
            wdata2 = $urandom;
            model(1, 32'(4 * i), wdata2, 4'hF, erd, ee);
            txn2(1, 32'(4 * i), wdata2, 4'hF, rd, e);
        end
        for (int i = 0; i < 1000; i++) begin
            logic        w;
            logic [31:0] a;
            logic [31:0] d;
            logic [3:0]  b;
            w = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 15)) << 10);
            d = $urandom;
            b = 4'($urandom_range(0, 15));
            model(w, a, d, b, erd, ee);
            txn2(w, a, d, b, rd, e);
            chk("rnd_rdata", rd, erd);
            chk1("rnd_err", e, ee);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
